// File: rtl/bus_pkg.sv
// Shared definitions for the backplane bus master/target ports.
// Holds the master FSM state encoding and the default bus widths.
package bus_pkg;

  localparam int BUS_AW = 16;
  localparam int BUS_DW = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    OWN  = 2'd2,
    DONE = 2'd3
  } bm_state_t;

endpackage

// File: rtl/tmo_counter.sv
// Saturating cycle counter that flags when MAX cycles have been counted.
// MAX = 0 disables the expiry flag entirely.
module tmo_counter #(
  parameter int MAX = 255
) (
  input  logic clk,
  input  logic clrn,
  input  logic en,
  input  logic clr,
  output logic expired
);

  localparam int CW = (MAX > 0) ? $clog2(MAX + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(MAX);

  logic [CW-1:0] r_count;

  // Counting stops at LIMIT so a long wait never wraps back to zero.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en && (r_count != LIMIT)) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign expired = (MAX != 0) && (r_count == LIMIT);

endmodule

// File: rtl/bus_master_port.sv
// Master-side handshake front end for the shared backplane bus.
// Takes one client command, requests the bus, drives it while granted, reports completion.
module bus_master_port
  import bus_pkg::*;
#(
  parameter int AW        = BUS_AW,
  parameter int DW        = BUS_DW,
  parameter int GRANT_TMO = 255
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_error,
  output logic          BARQ,
  input  logic          BAGD,
  input  logic          DataStrobe,
  input  logic          Error,
  output logic          bus_oe,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  output logic          bus_we,
  input  logic [DW-1:0] bus_rdata
);

  bm_state_t     r_state;
  bm_state_t     w_next_state;
  logic          r_err;
  logic          w_next_err;
  logic          w_capture_rdata;
  logic          w_accept;
  logic          w_expired;
  logic          w_tmo_clr;

  logic          r_write;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rdata;

  assign w_accept  = (r_state == IDLE) && cmd_valid;
  assign w_tmo_clr = (r_state != REQ);

  tmo_counter #(
    .MAX(GRANT_TMO)
  ) u_tmo (
    .clk    (clk),
    .clrn   (clrn),
    .en     (r_state == REQ),
    .clr    (w_tmo_clr),
    .expired(w_expired)
  );

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state <= IDLE;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_err   <= w_next_err;
    end
  end

  // Error outranks DataStrobe; a grant lost without any strobe also counts as a failure.
  always_comb begin
    w_next_state    = r_state;
    w_next_err      = r_err;
    w_capture_rdata = 1'b0;
    case (r_state)
      IDLE: begin
        if (cmd_valid) begin
          w_next_state = REQ;
        end
      end
      REQ: begin
        if (BAGD) begin
          w_next_state = OWN;
        end else if (w_expired) begin
          w_next_state = DONE;
          w_next_err   = 1'b1;
        end
      end
      OWN: begin
        if (Error) begin
          w_next_state = DONE;
          w_next_err   = 1'b1;
        end else if (DataStrobe) begin
          w_next_state    = DONE;
          w_next_err      = 1'b0;
          w_capture_rdata = !r_write;
        end else if (!BAGD) begin
          w_next_state = DONE;
          w_next_err   = 1'b1;
        end
      end
      DONE: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_write <= cmd_write;
      r_addr  <= cmd_addr;
      r_wdata <= cmd_wdata;
    end
  end

  // Read data survives failed and write transactions; only a good read replaces it.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_rdata <= '0;
    end else if (w_capture_rdata) begin
      r_rdata <= bus_rdata;
    end
  end

  assign cmd_ready = (r_state == IDLE);
  assign BARQ      = (r_state == REQ) || (r_state == OWN);
  assign bus_oe    = (r_state == OWN) && BAGD;
  assign bus_addr  = bus_oe ? r_addr  : '0;
  assign bus_wdata = bus_oe ? r_wdata : '0;
  assign bus_we    = bus_oe && r_write;
  assign rsp_valid = (r_state == DONE);
  assign rsp_error = (r_state == DONE) && r_err;
  assign rsp_rdata = r_rdata;

endmodule

// File: tb/tb_bus_master_port.sv
// Directed bench for bus_master_port with a response scoreboard.
// Expected responses are queued when a command is issued and checked on rsp_valid.
module tb_bus_master_port;

  typedef struct packed {
    logic        err;
    logic [15:0] rdata;
  } rsp_t;

  logic        clk;
  logic        clrn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [15:0] cmd_addr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_error;
  logic        BARQ;
  logic        BAGD;
  logic        DataStrobe;
  logic        Error;
  logic        bus_oe;
  logic [15:0] bus_addr;
  logic [15:0] bus_wdata;
  logic        bus_we;
  logic [15:0] bus_rdata;

  int   checks = 0;
  int   errors = 0;
  rsp_t expQ[$];
  rsp_t popped;

  bus_master_port #(
    .AW(16),
    .DW(16),
    .GRANT_TMO(4)
  ) dut (
    .clk       (clk),
    .clrn      (clrn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_error (rsp_error),
    .BARQ      (BARQ),
    .BAGD      (BAGD),
    .DataStrobe(DataStrobe),
    .Error     (Error),
    .bus_oe    (bus_oe),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_we    (bus_we),
    .bus_rdata (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one command in IDLE, holds it over the accepting edge, then confirms BARQ.
  task automatic applyStimulus(input logic wr, input logic [15:0] addr, input logic [15:0] wdata);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    #1;
    checkOutput("cmd_ready_idle", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
    #1;
    checkOutput("barq_after_accept", BARQ, 1);
  endtask

  // Scoreboard: every completion pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (clrn && rsp_valid) begin
      checkOutput("sb_has_expect", (expQ.size() != 0), 1);
      if (expQ.size() != 0) begin
        popped = expQ.pop_front();
        checkOutput("sb_rsp_error", rsp_error, popped.err);
        checkOutput("sb_rsp_rdata", rsp_rdata, popped.rdata);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no end of test, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  n;
    logic sawOe;
    logic done;

    clrn       = 1'b0;
    cmd_valid  = 1'b0;
    cmd_write  = 1'b0;
    cmd_addr   = '0;
    cmd_wdata  = '0;
    BAGD       = 1'b0;
    DataStrobe = 1'b0;
    Error      = 1'b0;
    bus_rdata  = '0;

    #12;
    checkOutput("rst_cmd_ready", cmd_ready, 1);
    checkOutput("rst_barq", BARQ, 0);
    checkOutput("rst_bus_oe", bus_oe, 0);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_rsp_rdata", rsp_rdata, 0);
    checkOutput("rst_bus_addr", bus_addr, 0);
    step();
    clrn = 1'b1;

    // Write, grant two cycles after BARQ, strobe on the third owned cycle.
    expQ.push_back('{err: 1'b0, rdata: 16'h0000});
    applyStimulus(1'b1, 16'h0012, 16'hBEEF);
    step();
    step();
    BAGD = 1'b1;
    #1;
    checkOutput("wr_oe_in_req", bus_oe, 0);
    step();
    checkOutput("wr_bus_oe", bus_oe, 1);
    checkOutput("wr_bus_we", bus_we, 1);
    checkOutput("wr_bus_addr", bus_addr, 16'h0012);
    checkOutput("wr_bus_wdata", bus_wdata, 16'hBEEF);
    step();
    step();
    DataStrobe = 1'b1;
    step();
    DataStrobe = 1'b0;
    BAGD       = 1'b0;
    #1;
    checkOutput("wr_rsp_valid", rsp_valid, 1);
    checkOutput("wr_rsp_error", rsp_error, 0);
    checkOutput("wr_barq_done", BARQ, 0);
    checkOutput("wr_oe_done", bus_oe, 0);
    step();
    checkOutput("wr_rsp_pulse_end", rsp_valid, 0);
    checkOutput("wr_back_idle", cmd_ready, 1);

    // Grant timeout: no BAGD, expect abort after five REQ cycles.
    expQ.push_back('{err: 1'b1, rdata: 16'h0000});
    applyStimulus(1'b0, 16'h0077, 16'h0000);
    n     = 0;
    sawOe = 1'b0;
    done  = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      step();
      n++;
      if (bus_oe) sawOe = 1'b1;
      if (rsp_valid) done = 1'b1;
    end
    checkOutput("tmo_cycles", n, 5);
    checkOutput("tmo_rsp_error", rsp_error, 1);
    checkOutput("tmo_no_oe", sawOe, 0);
    checkOutput("tmo_barq_low", BARQ, 0);
    step();

    // Error and DataStrobe together on a read: error wins, read data untouched.
    expQ.push_back('{err: 1'b1, rdata: 16'h0000});
    applyStimulus(1'b0, 16'h0033, 16'h0000);
    BAGD = 1'b1;
    step();
    bus_rdata  = 16'hAAAA;
    DataStrobe = 1'b1;
    Error      = 1'b1;
    step();
    DataStrobe = 1'b0;
    Error      = 1'b0;
    BAGD       = 1'b0;
    bus_rdata  = '0;
    #1;
    checkOutput("both_rsp_error", rsp_error, 1);
    checkOutput("both_rsp_rdata", rsp_rdata, 16'h0000);
    checkOutput("both_cmd_ready", cmd_ready, 0);
    step();
    checkOutput("both_idle_2cyc", cmd_ready, 1);

    // Read with a stale grant already high in IDLE; grant on REQ entry is accepted.
    BAGD = 1'b1;
    #1;
    checkOutput("stale_oe_idle", bus_oe, 0);
    checkOutput("stale_barq_idle", BARQ, 0);
    expQ.push_back('{err: 1'b0, rdata: 16'h1234});
    applyStimulus(1'b0, 16'h0040, 16'h5555);
    checkOutput("rd_oe_in_req", bus_oe, 0);
    step();
    checkOutput("rd_bus_oe", bus_oe, 1);
    checkOutput("rd_bus_we", bus_we, 0);
    checkOutput("rd_bus_addr", bus_addr, 16'h0040);
    bus_rdata  = 16'h1234;
    DataStrobe = 1'b1;
    step();
    DataStrobe = 1'b0;
    BAGD       = 1'b0;
    bus_rdata  = '0;
    #1;
    checkOutput("rd_rsp_rdata", rsp_rdata, 16'h1234);
    checkOutput("rd_rsp_error", rsp_error, 0);
    checkOutput("rd_barq_after_strobe", BARQ, 0);
    step();
    checkOutput("rd_rdata_hold", rsp_rdata, 16'h1234);

    // Grant withdrawn mid-OWN; a second command is held off while busy.
    expQ.push_back('{err: 1'b1, rdata: 16'h1234});
    applyStimulus(1'b1, 16'h0100, 16'h0F0F);
    BAGD = 1'b1;
    step();
    checkOutput("drop_oe_owned", bus_oe, 1);
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 16'h0999;
    #1;
    checkOutput("busy_cmd_ready", cmd_ready, 0);
    step();
    BAGD = 1'b0;
    #1;
    checkOutput("drop_oe_same_cycle", bus_oe, 0);
    checkOutput("drop_addr_zero", bus_addr, 0);
    checkOutput("drop_barq_still", BARQ, 1);
    step();
    cmd_valid = 1'b0;
    #1;
    checkOutput("drop_rsp_valid", rsp_valid, 1);
    checkOutput("drop_rsp_error", rsp_error, 1);
    step();
    checkOutput("drop_back_idle", cmd_ready, 1);
    checkOutput("drop_no_reaccept", BARQ, 0);

    // Asynchronous reset while owning the bus drops everything immediately.
    applyStimulus(1'b0, 16'h0200, 16'h0000);
    BAGD = 1'b1;
    step();
    checkOutput("arst_oe_before", bus_oe, 1);
    #2;
    clrn = 1'b0;
    #1;
    checkOutput("arst_barq", BARQ, 0);
    checkOutput("arst_bus_oe", bus_oe, 0);
    checkOutput("arst_rsp_valid", rsp_valid, 0);
    checkOutput("arst_cmd_ready", cmd_ready, 1);
    checkOutput("arst_rsp_rdata", rsp_rdata, 0);
    BAGD = 1'b0;
    step();
    clrn = 1'b1;
    step();

    expQ.push_back('{err: 1'b0, rdata: 16'h00C3});
    applyStimulus(1'b0, 16'h0300, 16'h0000);
    BAGD = 1'b1;
    step();
    checkOutput("post_rst_oe", bus_oe, 1);
    checkOutput("post_rst_addr", bus_addr, 16'h0300);
    bus_rdata  = 16'h00C3;
    DataStrobe = 1'b1;
    step();
    DataStrobe = 1'b0;
    BAGD       = 1'b0;
    bus_rdata  = '0;
    #1;
    checkOutput("post_rst_rsp_valid", rsp_valid, 1);
    checkOutput("post_rst_rdata", rsp_rdata, 16'h00C3);
    step();
    step();

    checkOutput("sb_drained", expQ.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
